// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: shared state encodings and default sizing for the
// display arbiter and its data path.
package display_arbiter_pkg;

    // FSM encodings, kept as plain constants so legacy code sees the same values
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [1:0] BLANK  = 2'd3;

    // Default data width (one 7-segment word) and anti-flicker dwell
    localparam int N_DEFAULT    = 7;
    localparam int HOLD_DEFAULT = 50;

    // Grant state belonging to a requester index (0 or 1)
    function automatic logic [1:0] grant_of(input logic who);
        return who ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/mux2x1.sv
// mux2x1: N-bit two-input multiplexer (sel=0 -> d0, sel=1 -> d1).
module mux2x1 #(
    parameter int N = 7
) (
    input  logic         sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    output logic [N-1:0] y
);

    // Pure select, no storage
    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of a shared 2:1 display data path with a
// minimum-dwell counter so a busy requester is not preempted every cycle.
// Build option: define ARB_BLANK_EN to insert a one-cycle all-zero BLANK word
// between owners; without it ownership passes directly from one grant to the
// other.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic [N-1:0] OUT,
    output logic         busy
);

    localparam int              CW     = $clog2(HOLD + 1);
    localparam logic [CW-1:0]   HOLD_C = CW'(HOLD);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          last;
    logic [CW-1:0] cnt;
    logic          in_grant;
    logic          owner;
    logic          own_req;
    logic          other_req;
    logic          entering;
    logic [N-1:0]  mux_y;

`ifdef ARB_BLANK_EN
    logic          target;
`endif

    // Requester view of the current grant: who owns, do they still want it,
    // and is the other side waiting
    always_comb begin
        in_grant  = (state == GRANT0) || (state == GRANT1);
        owner     = (state == GRANT1);
        own_req   = owner ? req1 : req0;
        other_req = owner ? req0 : req1;
    end

    // Next-state selection for the arbitration FSM
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = grant_of(~last);
                end else if (req0) begin
                    next_state = GRANT0;
                end else if (req1) begin
                    next_state = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // A release is served before the dwell check, so a release
                // coinciding with the other's request never waits out HOLD.
                if (!own_req || (other_req && (cnt == HOLD_C))) begin
                    if (other_req) begin
`ifdef ARB_BLANK_EN
                        next_state = BLANK;
`else
                        next_state = grant_of(~owner);
`endif
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            BLANK: begin
`ifdef ARB_BLANK_EN
                if (target ? req1 : req0) begin
                    next_state = grant_of(target);
                end else if (target ? req0 : req1) begin
                    next_state = grant_of(~target);
                end else begin
                    next_state = IDLE;
                end
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // A grant is newly taken when the FSM moves into a grant it is not already in
    always_comb begin
        entering = ((next_state == GRANT0) || (next_state == GRANT1))
                   && (next_state != state);
    end

    // State register plus registered output decodes of the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
            busy  <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            gnt0  <= (next_state == GRANT0);
            gnt1  <= (next_state == GRANT1);
            busy  <= (next_state == GRANT0) || (next_state == GRANT1);
            if (next_state == GRANT0) begin
                sel <= 1'b0;
            end else if (next_state == GRANT1) begin
                sel <= 1'b1;
            end
            if (entering) begin
                last <= (next_state == GRANT1);
            end
        end
    end

`ifdef ARB_BLANK_EN
    // Remember which requester the BLANK cycle is handing over to
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target <= 1'b0;
        end else if (in_grant && (next_state == BLANK)) begin
            target <= ~owner;
        end
    end
`endif

    // Dwell counter: counts while the other side waits, saturates at HOLD
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (entering) begin
            cnt <= '0;
        end else if (in_grant && other_req) begin
            if (cnt != HOLD_C) begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    mux2x1 #(.N(N)) u_mux (
        .sel (sel),
        .d0  (D0),
        .d1  (D1),
        .y   (mux_y)
    );

    // Output word: selected source while granted, zero otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            OUT <= '0;
        end else if (in_grant) begin
            OUT <= mux_y;
        end else begin
            OUT <= '0;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed scoreboard bench for display_arbiter with
// HOLD=4. Expected words are {gnt0,gnt1,sel,busy,OUT}; separate columns hold
// the values for builds with and without ARB_BLANK_EN.
module tb_display_arbiter;

    localparam int N    = 7;
    localparam int HOLD = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0  = 1'b0;
    logic         req1  = 1'b0;
    logic [N-1:0] D0    = 7'h3F;
    logic [N-1:0] D1    = 7'h06;
    logic         gnt0;
    logic         gnt1;
    logic         sel;
    logic         busy;
    logic [N-1:0] OUT;

    int tests   = 0;
    int fails   = 0;
    int step_no = 0;

    typedef struct {
        int          id;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];

    display_arbiter #(.N(N), .HOLD(HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .D0    (D0),
        .D1    (D1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .sel   (sel),
        .OUT   (OUT),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] pk(input logic g0, input logic g1,
                                       input logic s, input logic b,
                                       input logic [6:0] o);
        return {g0, g1, s, b, o};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic cyc(input logic rst, input logic r0, input logic r1,
                       input logic [6:0] d0, input logic [6:0] d1,
                       input logic [10:0] exp_blank, input logic [10:0] exp_direct);
        exp_t e;
        @(negedge clock);
        reset = rst;
        req0  = r0;
        req1  = r1;
        D0    = d0;
        D1    = d1;
        step_no++;
        e.id = step_no;
`ifdef ARB_BLANK_EN
        e.v = exp_blank;
`else
        e.v = exp_direct;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: one observation per clock, compared against the queued expectation
    initial begin : monitor
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {gnt0, gnt1, sel, busy, OUT};
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL step_%0d: got gnt0/gnt1/sel/busy/OUT=%b/%b/%b/%b/%h, expected %b/%b/%b/%b/%h",
                             e.id, act[10], act[9], act[8], act[7], act[6:0],
                             e.v[10], e.v[9], e.v[8], e.v[7], e.v[6:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [10:0] act;
        // Reset held with req0 high: everything stays clear
        cyc(1, 1, 0, 7'h3F, 7'h06, pk(0,0,0,0,7'h00), pk(0,0,0,0,7'h00));
        cyc(1, 1, 0, 7'h3F, 7'h06, pk(0,0,0,0,7'h00), pk(0,0,0,0,7'h00));
        // Release: grant at first edge, D0 on OUT one edge later
        cyc(0, 1, 0, 7'h3F, 7'h06, pk(1,0,0,1,7'h00), pk(1,0,0,1,7'h00));
        cyc(0, 1, 0, 7'h3F, 7'h06, pk(1,0,0,1,7'h3F), pk(1,0,0,1,7'h3F));
        // req1 waits: four counting cycles, live D0 change followed
        cyc(0, 1, 1, 7'h3F, 7'h06, pk(1,0,0,1,7'h3F), pk(1,0,0,1,7'h3F));
        cyc(0, 1, 1, 7'h3F, 7'h06, pk(1,0,0,1,7'h3F), pk(1,0,0,1,7'h3F));
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(1,0,0,1,7'h5B), pk(1,0,0,1,7'h5B));
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(1,0,0,1,7'h5B), pk(1,0,0,1,7'h5B));
        // Dwell expired: preemption toward requester 1
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(0,0,0,0,7'h5B), pk(0,1,1,1,7'h5B));
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h00), pk(0,1,1,1,7'h06));
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h06), pk(0,1,1,1,7'h06));
        // req1 owns, req0 gone, then req1 drops -> IDLE, OUT clears one edge later
        cyc(0, 0, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h06), pk(0,1,1,1,7'h06));
        cyc(0, 0, 0, 7'h5B, 7'h06, pk(0,0,1,0,7'h06), pk(0,0,1,0,7'h06));
        cyc(0, 0, 0, 7'h5B, 7'h06, pk(0,0,1,0,7'h00), pk(0,0,1,0,7'h00));
        // Re-enter GRANT1 from IDLE
        cyc(0, 0, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h00), pk(0,1,1,1,7'h00));
        cyc(0, 0, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h06), pk(0,1,1,1,7'h06));
        // Asynchronous reset mid-GRANT1, between clock edges
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        act = {gnt0, gnt1, sel, busy, OUT};
        tests++;
        if (act !== pk(0,0,0,0,7'h00)) begin
            fails++;
            $display("FAIL async_reset: got gnt0/gnt1/sel/busy/OUT=%b/%b/%b/%b/%h, expected 0/0/0/0/00",
                     act[10], act[9], act[8], act[7], act[6:0]);
        end
        cyc(1, 1, 1, 7'h5B, 7'h06, pk(0,0,0,0,7'h00), pk(0,0,0,0,7'h00));
        // Tie after reset goes to requester 0
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(1,0,0,1,7'h00), pk(1,0,0,1,7'h00));
        // req0 releases while req1 waits: handover without dwell
        cyc(0, 0, 1, 7'h5B, 7'h06, pk(0,0,0,0,7'h5B), pk(0,1,1,1,7'h5B));
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h00), pk(0,1,1,1,7'h06));
        cyc(0, 1, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h06), pk(0,1,1,1,7'h06));
        // req1 releases toward req0, then req0 drops during the handover
        cyc(0, 1, 0, 7'h5B, 7'h06, pk(0,0,1,0,7'h06), pk(1,0,0,1,7'h06));
        cyc(0, 0, 1, 7'h5B, 7'h06, pk(0,1,1,1,7'h00), pk(0,1,1,1,7'h5B));
        cyc(0, 0, 0, 7'h5B, 7'h06, pk(0,0,1,0,7'h06), pk(0,0,1,0,7'h06));
        cyc(0, 0, 0, 7'h5B, 7'h06, pk(0,0,1,0,7'h00), pk(0,0,1,0,7'h00));
        // Let the monitor drain, bounded
        repeat (3) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares one 2:1 data path (two N-bit display sources, one sink) between two requesters.
- Round-robin arbitration with a minimum-dwell (anti-flicker) counter; drives the mux select and registers the selected word.
- Sits between two game sub-systems (e.g. score/sequence display) and the 7-segment decoder chain.
- Instantiates the team's mux2x1 for the data path.

Parameters:
N, 7, data width of each source and of OUT
HOLD, 50, minimum cycles a grant is kept once the other requester is waiting (must be >= 1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 wants the sink (level)
req1  input  1  requester 1 wants the sink (level)
D0  input  N  data from requester 0
D1  input  N  data from requester 1
gnt0  output  1  requester 0 owns the sink
gnt1  output  1  requester 1 owns the sink
sel  output  1  mux select (0 = D0, 1 = D1), also fed to the internal mux2x1
OUT  output  N  registered selected data
busy  output  1  any grant active

Behaviour:
- One clock, clock; reset asynchronous active-high. Reset: state=IDLE, gnt0=gnt1=0, sel=0, OUT=0, busy=0, last=1 (so req0 wins the first tie), hold counter=0.
- FSM states: IDLE, GRANT0, GRANT1, BLANK. gnt0/gnt1/sel/busy are registered decodes of the state. sel holds its last value in IDLE/BLANK. gnt0 and gnt1 are never both 1.
- IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> the requester != last; none -> stay.
- GRANTx entry: counter cleared, last<=x.
- Counter increments each cycle in GRANTx while the other requester is asserted. It saturates at HOLD and clears whenever the other request is low.
- GRANTx exit:
  - reqx low -> if other req high, BLANK then GRANTother; else IDLE.
  - reqx high, other high, counter==HOLD -> BLANK then GRANTother (preemption).
  - Otherwise stay.
- BLANK: one cycle. OUT=0, gnt0=gnt1=0, then the pending target grant. If the target request dropped during BLANK: go to the other request if asserted, else IDLE.
- OUT register: OUT(t+1)=D_sel(t) while in GRANTx; OUT<=0 in IDLE and BLANK.
- Latency: req rises at edge t in IDLE -> gnt/sel at t+1 -> first valid OUT at t+2.
- Simultaneous events: release and the other's request in the same cycle is handled as a release (no dwell wait).
- Reset mid-grant forces IDLE and OUT=0 immediately (asynchronous).
- Counter width is $clog2(HOLD+1); no wrap.

Optional Feature:
- Macro ARB_BLANK_EN.
- Defined: BLANK state as described; OUT is 0 for exactly one cycle on every handover.
- Undefined: BLANK is omitted. Handover goes directly GRANTx -> GRANTother in one cycle; OUT switches source without a zero word. All other rules are unchanged.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, BLANK=2'd3
  - default HOLD constant
- Sub-module: mux2x1 (parameter N), for the select path. FSM, counter and OUT register stay in display_arbiter.

Test Plan:
- Reset with req0=1: gnt0=gnt1=0, OUT=0 during reset. After release: gnt0=1 at next edge, OUT=D0 (e.g. 7'h3F) one cycle later.
- req0 and req1 rise together from IDLE after reset -> gnt0 first. Drop req0, raise again with req1 held -> after BLANK, gnt1.
- HOLD=4, req0 held, req1 asserted -> gnt0 stays exactly 4 counting cycles, one BLANK cycle with OUT=0, then gnt1=1, sel=1, OUT=D1.
- req1 owns sink, req1 drops while req0 low -> IDLE next edge, busy=0, OUT=0 one cycle later.
- Assert reset asynchronously mid-GRANT1 -> gnt1, busy, OUT clear without a clock edge. Restart arbitration on release.
- Build without ARB_BLANK_EN, repeat the preemption case -> OUT changes D0->D1 with no zero cycle, and gnt never overlaps.
